// File: rtl/window_overlap_add.sv
// Overlap-add reconstruction: sums each frame's first half with the stored second half of the previous frame.
// Optional OLA_FLUSH_EN adds a flush port that drains the stored tail as a final half-frame.
module window_overlap_add #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic             frame_err
`ifdef OLA_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int unsigned HOP = SIZE / 2;
    localparam int unsigned IW  = $clog2(SIZE);
    localparam int unsigned TW  = (HOP > 1) ? $clog2(HOP) : 1;
    localparam logic [IW-1:0] LAST  = IW'(SIZE - 1);
    localparam logic [IW-1:0] HOP_I = IW'(HOP);

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] tail [HOP];
    logic             head;
    logic [TW-1:0]    hidx;
    logic [TW-1:0]    tidx;
    logic [WIDTH:0]   sum;
    logic             in_fire;
    logic             out_fire;
    logic             accept_en;
    logic             flush_load;
    logic             flush_end;

`ifdef OLA_FLUSH_EN
    typedef enum logic {ST_ACCEPT, ST_FLUSH} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACCEPT;
        else        state <= state_nxt;
    end
`endif

    assign head     = (idx < HOP_I);
    assign hidx     = TW'(idx);
    assign tidx     = TW'(idx - HOP_I);
    assign sum      = {1'b0, in_data} + {1'b0, tail[hidx]};
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // During FLUSH idx is reused as the read pointer into the tail
    always_comb begin
        accept_en  = 1'b1;
        flush_load = 1'b0;
        flush_end  = 1'b0;
`ifdef OLA_FLUSH_EN
        state_nxt  = state;
        accept_en  = (state == ST_ACCEPT) && !(flush && idx == '0);
        flush_load = (state == ST_FLUSH) && (idx < HOP_I) && (!out_valid || out_ready);
        flush_end  = (state == ST_FLUSH) && (idx == HOP_I) && out_fire;
        if (state == ST_ACCEPT && flush && idx == '0) state_nxt = ST_FLUSH;
        else if (flush_end)                           state_nxt = ST_ACCEPT;
`endif
        in_ready = accept_en && (!head || !out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            tail      <= '{default: '0};
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (out_fire) out_valid <= 1'b0;
            if (in_fire) begin
                if (head) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                end else if (!(in_last && idx != LAST)) begin
                    tail[tidx] <= in_data;
                end
                // an early in_last or a missing one both resynchronise to idx 0
                frame_err <= in_last ^ (idx == LAST);
                if (in_last || idx == LAST) idx <= '0;
                else                        idx <= idx + IW'(1);
            end else if (flush_load) begin
                out_data  <= {1'b0, tail[hidx]};
                out_valid <= 1'b1;
                idx       <= idx + IW'(1);
            end
            if (flush_end) begin
                tail <= '{default: '0};
                idx  <= '0;
            end
        end
    end

endmodule
